// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - alarm slot store, per-minute matcher and ring/snooze/timeout FSM
// Lowest matching slot wins; matches that cannot be serviced raise a one-cycle missed pulse.
module alarm_scheduler #(
  parameter int NUM_SLOTS  = 7,
  parameter int SLOT_W     = 3,
  parameter int TIME_W     = 13,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MAX   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              minute_tick,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [2:0]        cur_day,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [TIME_W-1:0] wr_time,
  input  logic [6:0]        wr_days,
  input  logic              wr_enable,
  input  logic              ack,
  input  logic              snooze,
  output logic              alarm_on,
  output logic              snoozed,
  output logic [SLOT_W-1:0] active_slot,
  output logic              missed
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RING = 2'd1;
  localparam logic [1:0] ST_SNZ  = 2'd2;

  localparam int CNT_MAX = (RING_MAX > SNOOZE_MIN) ? RING_MAX : SNOOZE_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_INIT = CNT_W'(RING_MAX);
  localparam logic [CNT_W-1:0] SNZ_INIT  = CNT_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [TIME_W-1:0]    time_q [NUM_SLOTS];
  logic [TIME_W-1:0]    time_d [NUM_SLOTS];
  logic [6:0]           days_q [NUM_SLOTS];
  logic [6:0]           days_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] en_q, en_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]     snz_cnt_q, snz_cnt_d;
  logic [SLOT_W-1:0]    active_slot_q, active_slot_d;
  logic                 missed_q, missed_d;
  logic                 any_match;
  logic [SLOT_W-1:0]    win_slot;

  always_comb begin
    en_d = en_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      time_d[i] = time_q[i];
      days_d[i] = days_q[i];
      if (wr_en && (wr_slot == SLOT_W'(i))) begin
        time_d[i] = wr_time;
        days_d[i] = wr_days;
        en_d[i]   = wr_enable;
      end
    end
  end

  // Scan high to low so the lowest matching index is the one left in win_slot.
  always_comb begin
    any_match = 1'b0;
    win_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (minute_tick && en_q[i] && (time_q[i] == cur_time) &&
          (|({1'b0, days_q[i]} & (8'd1 << cur_day)))) begin
        any_match = 1'b1;
        win_slot  = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    active_slot_d = active_slot_q;
    missed_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_match) begin
          state_d       = ST_RING;
          active_slot_d = win_slot;
          ring_cnt_d    = RING_INIT;
        end
      end
      ST_RING: begin
        missed_d = any_match;
        if (ack) begin
          state_d       = ST_IDLE;
          active_slot_d = '0;
        end else if (snooze) begin
          state_d   = ST_SNZ;
          snz_cnt_d = SNZ_INIT;
        end else if (minute_tick) begin
          ring_cnt_d = ring_cnt_q - CNT_ONE;
          if (ring_cnt_q == CNT_ONE) begin
            state_d       = ST_IDLE;
            active_slot_d = '0;
            missed_d      = 1'b1;
          end
        end
      end
      ST_SNZ: begin
        missed_d = any_match;
        if (ack) begin
          state_d       = ST_IDLE;
          active_slot_d = '0;
        end else if (minute_tick) begin
          snz_cnt_d = snz_cnt_q - CNT_ONE;
          if (snz_cnt_q == CNT_ONE) begin
            state_d    = ST_RING;
            ring_cnt_d = RING_INIT;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        active_slot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        time_q[i] <= '0;
        days_q[i] <= '0;
      end
      en_q          <= '0;
      state_q       <= ST_IDLE;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      active_slot_q <= '0;
      missed_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        time_q[i] <= time_d[i];
        days_q[i] <= days_d[i];
      end
      en_q          <= en_d;
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      active_slot_q <= active_slot_d;
      missed_q      <= missed_d;
    end
  end

  assign alarm_on    = (state_q == ST_RING);
  assign snoozed     = (state_q == ST_SNZ);
  assign active_slot = active_slot_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - scoreboard bench for alarm_scheduler
// Expected {alarm_on, snoozed, active_slot, missed} words are queued with each stimulus cycle.
module tb_alarm_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        minute_tick;
  logic [12:0] cur_time;
  logic [2:0]  cur_day;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [12:0] wr_time;
  logic [6:0]  wr_days;
  logic        wr_enable;
  logic        ack;
  logic        snooze;
  logic        alarm_on;
  logic        snoozed;
  logic [2:0]  active_slot;
  logic        missed;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] exp_q[$];
  logic [5:0] got_q[$];
  string      tag_q[$];

  localparam logic [6:0] DAY2 = 7'b0000100;
  localparam logic [6:0] DAY5 = 7'b0100000;
  localparam logic [6:0] ALLD = 7'b1111111;

  alarm_scheduler dut (
    .clk(clk), .rst(rst), .minute_tick(minute_tick), .cur_time(cur_time),
    .cur_day(cur_day), .wr_en(wr_en), .wr_slot(wr_slot), .wr_time(wr_time),
    .wr_days(wr_days), .wr_enable(wr_enable), .ack(ack), .snooze(snooze),
    .alarm_on(alarm_on), .snoozed(snoozed), .active_slot(active_slot), .missed(missed)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input logic a, input logic s, input logic [2:0] sl,
                                    input logic m);
    return {a, s, sl, m};
  endfunction

  task automatic drive(input string tag, input logic tk, input logic [12:0] t,
                       input logic [2:0] d, input logic a, input logic s, input logic [5:0] e);
    minute_tick = tk; cur_time = t; cur_day = d; ack = a; snooze = s;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    got_q.push_back({alarm_on, snoozed, active_slot, missed});
    minute_tick = 1'b0; ack = 1'b0; snooze = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sl, input logic [12:0] t, input logic [6:0] dm,
                    input logic en);
    wr_en = 1'b1; wr_slot = sl; wr_time = t; wr_days = dm; wr_enable = en;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive("reset0", 0, 13'h0, 3'd0, 0, 0, ex(0, 0, 3'd0, 0));
    drive("reset1", 0, 13'h0, 3'd0, 0, 0, ex(0, 0, 3'd0, 0));
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  task automatic test_single_match();
    wr(3'd2, 13'h0ABC, DAY2, 1'b1);
    drive("wrong_day", 1, 13'h0ABC, 3'd3, 0, 0, ex(0, 0, 3'd0, 0));
    drive("day_match", 1, 13'h0ABC, 3'd2, 0, 0, ex(1, 0, 3'd2, 0));
    drive("ack_idle",  0, 13'h0,    3'd0, 1, 0, ex(0, 0, 3'd0, 0));
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  task automatic test_priority();
    wr(3'd1, 13'h0100, DAY5, 1'b1);
    wr(3'd4, 13'h0100, DAY5, 1'b1);
    drive("prio_low", 1, 13'h0100, 3'd5, 0, 0, ex(1, 0, 3'd1, 0));
    drive("prio_ack", 0, 13'h0,    3'd0, 1, 0, ex(0, 0, 3'd0, 0));
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  task automatic test_snooze();
    drive("snz_ring",  1, 13'h0100, 3'd5, 0, 0, ex(1, 0, 3'd1, 0));
    drive("snz_enter", 0, 13'h0,    3'd0, 0, 1, ex(0, 1, 3'd1, 0));
    drive("snz_again", 0, 13'h0,    3'd0, 0, 1, ex(0, 1, 3'd1, 0));
    for (int k = 1; k <= 4; k++)
      drive("snz_hold", 1, 13'h0001, 3'd0, 0, 0, ex(0, 1, 3'd1, 0));
    drive("snz_rering", 1, 13'h0100, 3'd5, 0, 0, ex(1, 0, 3'd1, 1));
    drive("snz_ack",    0, 13'h0,    3'd0, 1, 0, ex(0, 0, 3'd0, 0));
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  task automatic test_timeout();
    drive("to_ring", 1, 13'h0100, 3'd5, 0, 0, ex(1, 0, 3'd1, 0));
    for (int k = 1; k <= 9; k++)
      drive("to_hold", 1, 13'h0001, 3'd0, 0, 0, ex(1, 0, 3'd1, 0));
    drive("to_expire", 1, 13'h0001, 3'd0, 0, 0, ex(0, 0, 3'd0, 1));
    drive("to_pulse1", 0, 13'h0,    3'd0, 0, 0, ex(0, 0, 3'd0, 0));
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive("bb_ring",   1, 13'h0100, 3'd5, 0, 0, ex(1, 0, 3'd1, 0));
    drive("bb_acksnz", 0, 13'h0,    3'd0, 1, 1, ex(0, 0, 3'd0, 0));
    drive("bb_ring2",  1, 13'h0100, 3'd5, 0, 0, ex(1, 0, 3'd1, 0));
    wr(3'd3, 13'h0200, DAY5, 1'b1);
    wr(3'd1, 13'h0100, DAY5, 1'b0);
    drive("bb_disable", 0, 13'h0,    3'd0, 0, 0, ex(1, 0, 3'd1, 0));
    drive("bb_missed",  1, 13'h0200, 3'd5, 0, 0, ex(1, 0, 3'd1, 1));
    drive("bb_after",   0, 13'h0,    3'd0, 0, 0, ex(1, 0, 3'd1, 0));
    drive("bb_ack",     0, 13'h0,    3'd0, 1, 0, ex(0, 0, 3'd0, 0));
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  task automatic test_reset_and_days();
    drive("rd_ring", 1, 13'h0200, 3'd5, 0, 0, ex(1, 0, 3'd3, 0));
    drive("rd_snz",  0, 13'h0,    3'd0, 0, 1, ex(0, 1, 3'd3, 0));
    rst = 1'b1;
    drive("rd_rst",  0, 13'h0,    3'd0, 0, 0, ex(0, 0, 3'd0, 0));
    rst = 1'b0;
    drive("rd_cleared", 1, 13'h0200, 3'd5, 0, 0, ex(0, 0, 3'd0, 0));
    wr(3'd0, 13'h0300, ALLD, 1'b1);
    drive("rd_day7", 1, 13'h0300, 3'd7, 0, 0, ex(0, 0, 3'd0, 0));
    drive("rd_day6", 1, 13'h0300, 3'd6, 0, 0, ex(1, 0, 3'd0, 0));
    drive("rd_ack",  0, 13'h0,    3'd0, 1, 0, ex(0, 0, 3'd0, 0));
    wr(3'd7, 13'h0400, ALLD, 1'b1);
    drive("rd_badslot", 1, 13'h0400, 3'd1, 0, 0, ex(0, 0, 3'd0, 0));
    while (exp_q.size() > 0) begin
      logic [5:0] e = exp_q.pop_front();
      logic [5:0] g = got_q.pop_front();
      string nm = tag_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got {on,snz,slot,miss}=%b expected %b", nm, g, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; minute_tick = 1'b0; cur_time = '0; cur_day = '0;
    wr_en = 1'b0; wr_slot = '0; wr_time = '0; wr_days = '0; wr_enable = 1'b0;
    ack = 1'b0; snooze = 1'b0;
    test_reset();
    test_single_match();
    test_priority();
    test_snooze();
    test_timeout();
    test_back_to_back();
    test_reset_and_days();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
